i2s_stereo_tx: RTL and testbench

I2S_STEREO_TX -- requirements
Module: i2s_stereo_tx

---
 rtl/i2s_stereo_tx.sv | 171 +++++++++++++++++
 tb/tb_i2s_stereo_tx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_stereo_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_stereo_tx
// Brief    : One-entry buffered stereo word to I2S serializer (BCLK/LRCK/SDATA)
// Revision : 1.0 - initial release
// ============================================================================
module i2s_stereo_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int CH_BITS    = 16,
    parameter int BCLK_HALF  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  bclk,
    output logic                  lrck,
    output logic                  sdata,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam int SLOT_W = $clog2(DATA_WIDTH);
    localparam int DIV_W  = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

    localparam logic [SLOT_W-1:0] c_LAST_SLOT = SLOT_W'(DATA_WIDTH - 1);
    localparam logic [SLOT_W-1:0] c_LR_FIRST  = SLOT_W'(CH_BITS - 1);
    localparam logic [SLOT_W-1:0] c_LR_LAST   = SLOT_W'(DATA_WIDTH - 2);
    localparam logic [DIV_W-1:0]  c_DIV_LAST  = DIV_W'(BCLK_HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_buf_full;
    logic [DATA_WIDTH-1:0] r_buf_data;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DIV_W-1:0]      r_div;
    logic [SLOT_W-1:0]     r_slot;
    logic                  r_bclk;
    logic                  r_frame_start;
    logic                  r_underrun;

    logic                  w_active;
    logic                  w_div_wrap;
    logic                  w_fall_tick;
    logic                  w_frame_end;
    logic                  w_frame_load;
    logic                  w_accept;
    logic [SLOT_W-1:0]     w_bit_idx;

    assign w_active    = (r_state != S_IDLE);
    assign w_div_wrap  = w_active && (r_div == c_DIV_LAST);
    assign w_fall_tick = w_div_wrap && r_bclk;
    assign w_frame_end = w_fall_tick && (r_slot == c_LAST_SLOT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A frame is loaded either when leaving IDLE or seamlessly at the end of
    // slot 31 whenever the run request is (again) present.
    always_comb begin
        w_state_next = r_state;
        w_frame_load = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && r_buf_full) begin
                    w_state_next = S_RUN;
                    w_frame_load = 1'b1;
                end
            end
            S_RUN: begin
                if (w_frame_end) begin
                    if (enable) begin
                        w_frame_load = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else if (!enable) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_frame_end) begin
                    if (enable) begin
                        w_state_next = S_RUN;
                        w_frame_load = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else if (enable) begin
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign data_ready = rst || !r_buf_full || w_frame_load;
    assign w_accept   = data_valid && data_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_full <= 1'b0;
            r_buf_data <= '0;
        end else if (w_accept) begin
            r_buf_full <= 1'b1;
            r_buf_data <= data_in;
        end else if (w_frame_load) begin
            r_buf_full <= 1'b0;
        end
    end

    // Left channel goes out first, so it is placed in the upper half.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg <= '0;
        end else if (w_frame_load) begin
            r_shreg <= r_buf_full ? {r_buf_data[CH_BITS-1:0], r_buf_data[DATA_WIDTH-1:CH_BITS]}
                                  : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div         <= '0;
            r_bclk        <= 1'b0;
            r_slot        <= '0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_start <= w_frame_load;
            r_underrun    <= w_frame_load && !r_buf_full;
            if (w_frame_load || (w_state_next == S_IDLE)) begin
                r_div  <= '0;
                r_bclk <= 1'b0;
                r_slot <= '0;
            end else if (w_div_wrap) begin
                r_div  <= '0;
                r_bclk <= ~r_bclk;
                if (w_fall_tick) begin
                    r_slot <= r_slot + 1'b1;
                end
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign w_bit_idx   = c_LAST_SLOT - r_slot;
    assign bclk        = r_bclk;
    assign lrck        = w_active && (r_slot >= c_LR_FIRST) && (r_slot <= c_LR_LAST);
    assign sdata       = w_active && r_shreg[w_bit_idx];
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_i2s_stereo_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_stereo_tx
// Brief    : Directed self-checking bench for i2s_stereo_tx (BCLK_HALF = 2)
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_stereo_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic        bclk;
    logic        lrck;
    logic        sdata;
    logic        frame_start;
    logic        underrun;

    int checks   = 0;
    int failures = 0;
    int n_acc    = 0;
    int widx     = 0;
    logic feed   = 1'b0;

    localparam int NW = 5;
    logic [31:0] words [NW] = '{32'h1234_8001, 32'hDEAD_BEEF, 32'h0F0F_F0F0,
                                32'h8000_0001, 32'h5555_AAAA};

    always #5 clk = ~clk;

    i2s_stereo_tx #(
        .DATA_WIDTH (32),
        .CH_BITS    (16),
        .BCLK_HALF  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .bclk        (bclk),
        .lrck        (lrck),
        .sdata       (sdata),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    // Serial order of a stereo word: left half first, then right half.
    function automatic logic [31:0] lr_order(input logic [31:0] w);
        return {w[15:0], w[31:16]};
    endfunction

    // One clk: handshake sampled mid-cycle, outputs observed 1 time unit after the edge.
    task automatic step();
        logic acc;
        @(negedge clk);
        acc = data_valid && data_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            n_acc++;
            if (feed) begin
                widx++;
                if (widx < NW) begin
                    data_in = words[widx];
                end else begin
                    data_valid = 1'b0;
                    feed       = 1'b0;
                end
            end
        end
    endtask

    // Observe one 128-clk frame starting on its slot-0 cycle.
    task automatic run_frame(input int drop_at, output logic [31:0] ser, output logic [31:0] lr,
                             output int fs_cnt, output int ur_cnt, output int terr,
                             output int acc_load, output int acc_mid);
        int a0;
        ser = '0; lr = '0; fs_cnt = 0; ur_cnt = 0; terr = 0; acc_load = 0; acc_mid = 0;
        for (int n = 0; n < 128; n++) begin
            if (n % 4 == 0) begin
                ser[31 - n / 4] = sdata;
                lr[n / 4]       = lrck;
            end else if (sdata !== ser[31 - n / 4] || lrck !== lr[n / 4]) begin
                terr++;
            end
            if (bclk !== ((n % 4) >= 2)) terr++;
            if (frame_start === 1'b1) fs_cnt++;
            if (underrun === 1'b1) ur_cnt++;
            if (n == drop_at) enable = 1'b0;
            a0 = n_acc;
            step();
            if (n_acc != a0) begin
                if (n == 127) acc_load++;
                else acc_mid++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; data_valid = 1'b0; data_in = '0;
        step(); step();
        checks++;
        if ({bclk, lrck, sdata, frame_start, underrun} !== 5'b0) begin
            failures++; $display("FAIL reset_outputs: got %b expected 00000", {bclk, lrck, sdata, frame_start, underrun});
        end
        checks++;
        if (data_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", data_ready); end
        rst = 1'b0;
        step();
        checks++;
        if ({bclk, lrck, sdata} !== 3'b0) begin failures++; $display("FAIL idle_outputs: got %b expected 000", {bclk, lrck, sdata}); end
    endtask

    task automatic test_basic_frame();
        logic [31:0] ser, lr;
        int fs, ur, terr, al, am;
        enable = 1'b1;
        step();
        checks++;
        if ({frame_start, bclk} !== 2'b00) begin failures++; $display("FAIL idle_no_data: got %b expected 00", {frame_start, bclk}); end
        data_valid = 1'b1; data_in = 32'hA5A5_3C3C;
        step();
        data_valid = 1'b0;
        checks++;
        if (frame_start !== 1'b0) begin failures++; $display("FAIL fs_early: got %b expected 0", frame_start); end
        step();
        checks++;
        if (frame_start !== 1'b1) begin failures++; $display("FAIL fs_latency: got %b expected 1", frame_start); end
        checks++;
        if (underrun !== 1'b0) begin failures++; $display("FAIL basic_no_underrun: got %b expected 0", underrun); end
        run_frame(-1, ser, lr, fs, ur, terr, al, am);
        checks++;
        if (ser !== 32'h3C3C_A5A5) begin failures++; $display("FAIL basic_sdata: got %h expected 3c3ca5a5", ser); end
        checks++;
        if (lr !== 32'h7FFF_8000) begin failures++; $display("FAIL basic_lrck: got %h expected 7fff8000", lr); end
        checks++;
        if (terr !== 0) begin failures++; $display("FAIL basic_timing: got %0d errors expected 0", terr); end
        checks++;
        if (fs !== 1) begin failures++; $display("FAIL basic_fs_count: got %0d expected 1", fs); end
    endtask

    task automatic test_underrun();
        logic [31:0] ser, lr;
        int fs, ur, terr, al, am;
        checks++;
        if ({frame_start, underrun} !== 2'b11) begin failures++; $display("FAIL ur_pulse: got %b expected 11", {frame_start, underrun}); end
        run_frame(0, ser, lr, fs, ur, terr, al, am);
        checks++;
        if (ser !== 32'h0) begin failures++; $display("FAIL ur_sdata: got %h expected 00000000", ser); end
        checks++;
        if (ur !== 1) begin failures++; $display("FAIL ur_count: got %0d expected 1", ur); end
        checks++;
        if (terr !== 0) begin failures++; $display("FAIL ur_timing: got %0d errors expected 0", terr); end
        checks++;
        if ({bclk, lrck, sdata, frame_start, underrun} !== 5'b0) begin
            failures++; $display("FAIL ur_drain_idle: got %b expected 00000", {bclk, lrck, sdata, frame_start, underrun});
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ser, lr;
        int fs, ur, terr, al, am, a0;
        enable = 1'b1; feed = 1'b1; widx = 0; data_valid = 1'b1; data_in = words[0];
        a0 = n_acc;
        step();
        checks++;
        if (frame_start !== 1'b0) begin failures++; $display("FAIL bp_fs_early: got %b expected 0", frame_start); end
        step();
        checks++;
        if ({frame_start, sdata} !== 2'b11) begin failures++; $display("FAIL bp_first_bit: got %b expected 11", {frame_start, sdata}); end
        checks++;
        if (data_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low: got %b expected 0", data_ready); end
        checks++;
        if (n_acc - a0 !== 2) begin failures++; $display("FAIL bp_start_accepts: got %0d expected 2", n_acc - a0); end
        for (int k = 0; k < 3; k++) begin
            run_frame(-1, ser, lr, fs, ur, terr, al, am);
            checks++;
            if (ser !== lr_order(words[k])) begin
                failures++; $display("FAIL bp_frame%0d: got %h expected %h", k, ser, lr_order(words[k]));
            end
            checks++;
            if (al !== 1 || am !== 0) begin
                failures++; $display("FAIL bp_accepts%0d: got load=%0d mid=%0d expected load=1 mid=0", k, al, am);
            end
            checks++;
            if (lr !== 32'h7FFF_8000 || terr !== 0) begin
                failures++; $display("FAIL bp_lrck%0d: got %h/%0d expected 7fff8000/0", k, lr, terr);
            end
            checks++;
            if (frame_start !== 1'b1) begin failures++; $display("FAIL bp_period%0d: got %b expected 1", k, frame_start); end
        end
    endtask

    task automatic test_drain();
        logic [31:0] ser, lr;
        int fs, ur, terr, al, am, idle_err;
        run_frame(40, ser, lr, fs, ur, terr, al, am);
        checks++;
        if (ser !== lr_order(words[3])) begin failures++; $display("FAIL drain_sdata: got %h expected %h", ser, lr_order(words[3])); end
        checks++;
        if (al + am !== 0 || lr !== 32'h7FFF_8000 || terr !== 0) begin
            failures++; $display("FAIL drain_frame: got acc=%0d lr=%h terr=%0d expected 0/7fff8000/0", al + am, lr, terr);
        end
        idle_err = 0;
        for (int i = 0; i < 8; i++) begin
            if ({bclk, lrck, sdata, frame_start, underrun} !== 5'b0) idle_err++;
            step();
        end
        checks++;
        if (idle_err !== 0) begin failures++; $display("FAIL drain_idle: got %0d busy cycles expected 0", idle_err); end
        checks++;
        if (data_ready !== 1'b0) begin failures++; $display("FAIL drain_retained: got ready=%b expected 0", data_ready); end
        enable = 1'b1;
        step();
        checks++;
        if ({frame_start, underrun, sdata} !== 3'b101) begin
            failures++; $display("FAIL retained_load: got %b expected 101", {frame_start, underrun, sdata});
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] ser, lr;
        int fs, ur, terr, al, am, a0;
        for (int i = 0; i < 80; i++) step();
        checks++;
        if (lrck !== 1'b1) begin failures++; $display("FAIL mid_lrck_before: got %b expected 1", lrck); end
        rst = 1'b1;
        step();
        checks++;
        if ({bclk, lrck, sdata, frame_start, underrun, data_ready} !== 6'b000001) begin
            failures++; $display("FAIL mid_reset_outputs: got %b expected 000001", {bclk, lrck, sdata, frame_start, underrun, data_ready});
        end
        data_valid = 1'b1; data_in = 32'hC001_8000; enable = 1'b1;
        step();
        rst = 1'b0;
        a0 = n_acc;
        step();
        data_valid = 1'b0;
        checks++;
        if (n_acc - a0 !== 1 || frame_start !== 1'b0) begin
            failures++; $display("FAIL mid_accept: got acc=%0d fs=%b expected 1/0", n_acc - a0, frame_start);
        end
        step();
        checks++;
        if ({frame_start, sdata, lrck, bclk} !== 4'b1100) begin
            failures++; $display("FAIL mid_restart: got %b expected 1100", {frame_start, sdata, lrck, bclk});
        end
        run_frame(0, ser, lr, fs, ur, terr, al, am);
        checks++;
        if (ser !== 32'h8000_C001 || ur !== 0) begin
            failures++; $display("FAIL mid_frame: got %h ur=%0d expected 8000c001 ur=0", ser, ur);
        end
        checks++;
        if ({bclk, lrck, sdata, frame_start} !== 4'b0) begin
            failures++; $display("FAIL mid_final_idle: got %b expected 0000", {bclk, lrck, sdata, frame_start});
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_underrun();
        test_backpressure();
        test_drain();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
